// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick SPI responder: FSM states,
// default frame length, LED command opcode and the transmit byte layout.
package jstk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FRAME_BYTES_DEF = 5;

    localparam logic [5:0] LED_OPCODE = 6'b100000;

    localparam int BYTE_X_LO = 0;
    localparam int BYTE_X_HI = 1;
    localparam int BYTE_Y_LO = 2;
    localparam int BYTE_Y_HI = 3;
    localparam int BYTE_BTN  = 4;

    // Bytes past the report layout read as zero so longer frames pad cleanly.
    function automatic logic [7:0] tx_byte(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn,
        input int         idx
    );
        logic [7:0] b;
        case (idx)
            BYTE_X_LO: b = x[7:0];
            BYTE_X_HI: b = {6'b000000, x[9:8]};
            BYTE_Y_LO: b = y[7:0];
            BYTE_Y_HI: b = {6'b000000, y[9:8]};
            BYTE_BTN:  b = {5'b00000, btn};
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized level.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder reporting joystick position/buttons and accepting an
// LED command. Define JSTK_RESP_FRAME_CNT_EN to build the completed-frame counter.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic ss_q_s, ss_rise_raw_s, ss_fall_raw_s;
    logic sclk_q_s, sclk_rise_raw_s, sclk_fall_raw_s;
    logic mosi_q_s, mosi_rise_s, mosi_fall_s;
    logic unused_edges_s;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss), .q(ss_q_s), .rise(ss_rise_raw_s), .fall(ss_fall_raw_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_q_s), .rise(sclk_rise_raw_s), .fall(sclk_fall_raw_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_q_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_edges_s = sclk_q_s ^ mosi_rise_s ^ mosi_fall_s;

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [9:0]       x_snap_r, y_snap_r;
    logic [2:0]       btn_snap_r;
    logic [7:0]       rx_shift_r, cmd_r, rx_next_s;
    logic [7:0]       head_byte_s, cur_byte_s;
    logic             tx_bit_s;
    logic             miso_r, frame_done_r, frame_err_r, busy_r;
    logic [1:0]       led_r;
    logic             ss_rise_s, ss_fall_s, sclk_rise_s, sclk_fall_s;

    // A same-cycle ss rise wins over a fall; sclk is ignored while deselected.
    assign ss_rise_s   = ss_rise_raw_s;
    assign ss_fall_s   = ss_fall_raw_s & ~ss_rise_raw_s;
    assign sclk_rise_s = sclk_rise_raw_s & ~ss_q_s;
    assign sclk_fall_s = sclk_fall_raw_s & ~ss_q_s;

    // Transmit bit selection and receive shift value.
    always_comb begin
        head_byte_s = tx_byte(x_pos, y_pos, btn, BYTE_X_LO);
        cur_byte_s  = tx_byte(x_snap_r, y_snap_r, btn_snap_r, int'(bit_cnt_r[CNT_W-1:3]));
        rx_next_s   = {rx_shift_r[6:0], mosi_q_s};
        if (bit_cnt_r < CNT_W'(FRAME_BITS)) begin
            tx_bit_s = cur_byte_s[3'd7 - bit_cnt_r[2:0]];
        end else begin
            tx_bit_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ss_rise_s) begin
                    next_state_s = ST_IDLE;
                end else if (sclk_rise_s && (bit_cnt_r == CNT_W'(FRAME_BITS - 1))) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (ss_rise_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Frame datapath: snapshot, shifting, command capture and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r    <= {CNT_W{1'b0}};
            x_snap_r     <= 10'd0;
            y_snap_r     <= 10'd0;
            btn_snap_r   <= 3'd0;
            rx_shift_r   <= 8'h00;
            cmd_r        <= 8'h00;
            miso_r       <= 1'b0;
            led_r        <= 2'b00;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        x_snap_r   <= x_pos;
                        y_snap_r   <= y_pos;
                        btn_snap_r <= btn;
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        rx_shift_r <= 8'h00;
                        cmd_r      <= 8'h00;
                        miso_r     <= head_byte_s[7];
                    end else begin
                        miso_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise_s) begin
                        frame_err_r <= 1'b1;
                        miso_r      <= 1'b0;
                    end else begin
                        if (sclk_rise_s) begin
                            rx_shift_r <= rx_next_s;
                            bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                            if (bit_cnt_r == CNT_W'(7)) begin
                                cmd_r <= rx_next_s;
                            end
                        end
                        if (sclk_fall_s) begin
                            miso_r <= tx_bit_s;
                        end
                    end
                end
                ST_DONE: begin
                    miso_r <= 1'b0;
                    if (ss_rise_s) begin
                        frame_done_r <= 1'b1;
                        if (cmd_r[7:2] == LED_OPCODE) begin
                            led_r <= cmd_r[1:0];
                        end
                    end
                end
                default: miso_r <= 1'b0;
            endcase
        end
    end

`ifdef JSTK_RESP_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Completed-frame counter, wraps naturally at 256.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 8'h00;
        end else if ((state_r == ST_DONE) && ss_rise_s) begin
            frame_cnt_r <= frame_cnt_r + 8'h01;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 8'h00;
`endif

    assign miso       = miso_r;
    assign led        = led_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed, table-driven bench for jstk_spi_responder acting as a mode-0 SPI initiator.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       rst, ss, sclk, mosi, miso;
    logic [9:0] x_pos, y_pos;
    logic [2:0] btn;
    logic [1:0] led;
    logic       frame_done, frame_err, busy;
    logic [7:0] frame_cnt;

    jstk_spi_responder dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .led(led),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

`ifdef JSTK_RESP_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  b;
        logic [7:0]  cmd;
        int          nrise;
        logic [39:0] exp_rx;
        logic [1:0]  exp_led;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    // Count high cycles of each status pulse.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input int nrise, input logic [7:0] cmd, input int xchg_at,
                             output logic [39:0] got, output logic extra, output logic busy_mid);
        got = 40'h0;
        extra = 1'b0;
        busy_mid = 1'b0;
        ss = 1'b0;
        mosi = cmd[7];
        wait_clk(8);
        for (int i = 0; i < nrise; i++) begin
            if (i == xchg_at) x_pos = 10'h3FF;
            if (i < 40) got[39-i] = miso;
            else extra = extra | miso;
            if (i == 0) busy_mid = busy;
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            mosi = (i < 7) ? cmd[6-i] : 1'b0;
            wait_clk(4);
        end
        wait_clk(4);
        ss = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        logic [39:0] got, mask;
        logic extra, bmid;
        int d0, e0, n;

        vecs[0] = '{10'h2A5, 10'h103, 3'b101, 8'h00, 40, 40'hA5_02_03_01_05, 2'b00, 1, 0};
        vecs[1] = '{10'h3FF, 10'h000, 3'b111, 8'h83, 40, 40'hFF_03_00_00_07, 2'b11, 1, 0};
        vecs[2] = '{10'h155, 10'h2AA, 3'b010, 8'h40, 40, 40'h55_01_AA_02_02, 2'b11, 1, 0};
        vecs[3] = '{10'h000, 10'h3FF, 3'b000, 8'h81, 19, 40'h00_00_FF_03_00, 2'b11, 0, 1};
        vecs[4] = '{10'h001, 10'h200, 3'b100, 8'h82, 40, 40'h01_00_00_02_04, 2'b10, 1, 0};
        vecs[5] = '{10'h3C0, 10'h07F, 3'b011, 8'h81, 44, 40'hC0_03_7F_00_03, 2'b01, 1, 0};

        rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        x_pos = 10'h0; y_pos = 10'h0; btn = 3'b0;
        wait_clk(3);
        check("rst_miso", 64'(miso), 64'h0);
        check("rst_led", 64'(led), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(frame_done), 64'h0);
        check("rst_err", 64'(frame_err), 64'h0);
        check("rst_cnt", 64'(frame_cnt), 64'h0);
        rst = 1'b1;
        wait_clk(6);

        for (int v = 0; v < 6; v++) begin
            x_pos = vecs[v].x; y_pos = vecs[v].y; btn = vecs[v].b;
            d0 = done_cnt; e0 = err_cnt;
            spi_frame(vecs[v].nrise, vecs[v].cmd, -1, got, extra, bmid);
            mask = {40{1'b1}};
            if (vecs[v].nrise < 40) mask = mask << (40 - vecs[v].nrise);
            if (CNT_EN) exp_cnt = (exp_cnt + vecs[v].exp_done) % 256;
            check($sformatf("v%0d_rx", v), 64'(got & mask), 64'(vecs[v].exp_rx & mask));
            check($sformatf("v%0d_led", v), 64'(led), 64'(vecs[v].exp_led));
            check($sformatf("v%0d_done", v), 64'(done_cnt - d0), 64'(vecs[v].exp_done));
            check($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_busy_mid", v), 64'(bmid), 64'h1);
            check($sformatf("v%0d_busy_end", v), 64'(busy), 64'h0);
            check($sformatf("v%0d_miso_idle", v), 64'(miso), 64'h0);
            check($sformatf("v%0d_extra", v), 64'(extra), 64'h0);
            check($sformatf("v%0d_cnt", v), 64'(frame_cnt), 64'(exp_cnt));
        end

        // Position changes mid-frame must not leak into the frame in flight.
        x_pos = 10'h000; y_pos = 10'h000; btn = 3'b000;
        spi_frame(40, 8'h00, 10, got, extra, bmid);
        if (CNT_EN) exp_cnt = (exp_cnt + 1) % 256;
        check("snap_frame", 64'(got), 64'h0);
        spi_frame(40, 8'h00, -1, got, extra, bmid);
        if (CNT_EN) exp_cnt = (exp_cnt + 1) % 256;
        check("snap_next", 64'(got), 64'hFF_03_00_00_00);

        // Reset asserted after 12 sclk rises, led previously 01.
        d0 = done_cnt; e0 = err_cnt;
        ss = 1'b0; mosi = 1'b1;
        wait_clk(8);
        for (int i = 0; i < 12; i++) begin
            sclk = 1'b1; wait_clk(4); sclk = 1'b0; wait_clk(4);
        end
        rst = 1'b0;
        wait_clk(2);
        exp_cnt = 0;
        check("mrst_led", 64'(led), 64'h0);
        check("mrst_miso", 64'(miso), 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        rst = 1'b1;
        wait_clk(4);
        ss = 1'b1;
        wait_clk(8);
        check("mrst_err", 64'(err_cnt - e0), 64'h0);
        check("mrst_done", 64'(done_cnt - d0), 64'h0);
        check("mrst_busy_after", 64'(busy), 64'h0);
        check("mrst_cnt", 64'(frame_cnt), 64'h0);
        x_pos = 10'h2A5; y_pos = 10'h103; btn = 3'b101;
        d0 = done_cnt;
        spi_frame(40, 8'h83, -1, got, extra, bmid);
        if (CNT_EN) exp_cnt = (exp_cnt + 1) % 256;
        check("post_rst_rx", 64'(got), 64'hA5_02_03_01_05);
        check("post_rst_led", 64'(led), 64'h3);
        check("post_rst_done", 64'(done_cnt - d0), 64'h1);

        // Counter wrap (or stays at zero when the counter is not built).
        n = CNT_EN ? (256 - exp_cnt) : 3;
        d0 = done_cnt;
        for (int f = 0; f < n; f++) spi_frame(40, 8'h00, -1, got, extra, bmid);
        if (CNT_EN) exp_cnt = (exp_cnt + n) % 256;
        check("wrap_done", 64'(done_cnt - d0), 64'(n));
        check("wrap_cnt", 64'(frame_cnt), 64'(exp_cnt));
        check("wrap_led", 64'(led), 64'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flops per synchronizer on ss/sclk/mosi (legal 2..3).
REQ-002 SHALL have parameter FRAME_BYTES, default 5, meaning bytes per complete frame.
REQ-003 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port ss, input, 1, SPI slave select, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk, input, 1, SPI clock (mode 0), asynchronous to clk.
REQ-007 SHALL have port mosi, input, 1, command data from initiator.
REQ-008 SHALL have port miso, output, 1, response data to initiator.
REQ-009 SHALL have ports x_pos and y_pos, input, 10 each, stick position to report.
REQ-010 SHALL have port btn, input, 3, {stick_click, btn2, btn1} to report.
REQ-011 SHALL have port led, output, 2, LED state written by the initiator.
REQ-012 SHALL have ports frame_done and frame_err, output, 1 each, single-clk pulses.
REQ-013 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-014 SHALL have port frame_cnt, output, 8, count of completed frames.

Function
REQ-015 SHALL synchronize ss, sclk and mosi through SYNC_STAGES flops and detect sclk/ss edges on the synchronized signals; clk SHALL be at least 8x sclk.
REQ-016 SHALL implement FSM IDLE -> SHIFT on ss fall; SHIFT -> DONE after FRAME_BYTES*8 sclk rising edges; SHIFT or DONE -> IDLE on ss rise.
REQ-017 SHALL, on ss fall, snapshot x_pos, y_pos and btn into the transmit buffer so that a frame is internally consistent.
REQ-018 SHALL send bytes in order {x[7:0]}, {6'b0,x[9:8]}, {y[7:0]}, {6'b0,y[9:8]}, {5'b0,btn}, MSB first.
REQ-019 SHALL drive bit 7 of byte 0 on miso within 2 clk of ss-fall detection; each subsequent bit SHALL be driven within 2 clk of sclk-fall detection.
REQ-020 SHALL sample mosi on each sclk-rise detection into a byte shift register and record byte 0 as the command.
REQ-021 SHALL drive miso 0 in IDLE, in DONE, and for any sclk edges beyond FRAME_BYTES*8.
REQ-022 SHALL, on ss rise in DONE, pulse frame_done for 1 clk, increment frame_cnt modulo 256 (255 -> 0), and, if command[7:2] == 6'b100000, load led <= command[1:0].
REQ-023 SHALL, on ss rise in SHIFT (short frame), pulse frame_err for 1 clk and leave led and frame_cnt unchanged.
REQ-024 SHALL ignore sclk edges while ss is high.
REQ-025 SHALL assert busy in SHIFT and DONE only.
REQ-026 SHALL, if ss rise and ss fall are detected in the same clk (glitch shorter than the synchronizer), treat the event as ss rise only.

Reset
REQ-027 SHALL, while rst is low, force the FSM to IDLE, miso 0, led 2'b00, frame_cnt 0, busy 0, frame_done 0, frame_err 0, and clear all synchronizers.
REQ-028 SHALL, if rst asserts mid-frame, abort the frame without a frame_err pulse and await a fresh ss fall after release.

Configuration
REQ-029 SHALL implement frame_cnt only when macro JSTK_RESP_FRAME_CNT_EN is defined; without it, frame_cnt SHALL be tied to 8'h00 and have no counter logic.

Structure
REQ-030 SHALL place FSM state typedef, FRAME_BYTES default, LED command opcode 6'b100000 and byte-layout constants in shared package jstk_pkg.
REQ-031 SHALL instantiate one sub-module spi_sync (parameterized synchronizer plus rise/fall detector), used for ss, sclk and mosi.

Verification
REQ-032 SHALL cover: x=10'h2A5, y=10'h103, btn=3'b101, 5-byte frame -> miso bytes A5,02,03,01,05; frame_done 1 pulse; busy low after ss rise.
REQ-033 SHALL cover: command byte 0x83 in a full frame -> led=2'b11 after ss rise; command 0x40 -> led unchanged.
REQ-034 SHALL cover: ss rises after 19 sclk edges, command 0x81 -> frame_err 1 pulse, led unchanged, frame_cnt unchanged.
REQ-035 SHALL cover: x_pos changes 0x000 -> 0x3FF during a frame -> all 5 bytes report 0x000 value.
REQ-036 SHALL cover: 256 complete frames with JSTK_RESP_FRAME_CNT_EN defined -> frame_cnt wraps to 0; undefined -> frame_cnt stays 0.
REQ-037 SHALL cover: rst low at bit 12 of a frame -> led 00, miso 0, busy 0, no frame_err; next full frame completes normally.
